// File: rtl/shl_skid_pkg.sv
// Shared types and constants for the shl_skid_stage block.
// Optional OVF output is enabled by defining SHL_SKID_OVF_EN.
package shl_skid_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] amt;
    } operand_t;

endpackage

// File: rtl/coreir_shl.sv
// Combinational left shift with CoreIR semantics: result truncated to width,
// and any shift amount >= width yields zero.
module coreir_shl #(
    parameter int width = 1
) (
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    output logic [width-1:0] out
);

    assign out = in0 << in1;

endmodule

// File: rtl/shl_skid_buffer.sv
// Generic 2-entry ready/valid skid buffer: main entry feeds downstream, skid
// entry absorbs one transfer while main is stalled. in_ready is registered.
module shl_skid_buffer
    import shl_skid_pkg::*;
#(
    parameter type data_t = operand_t
) (
    input  logic  CLK,
    input  logic  RESET,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output data_t out_data
);

    data_t main_q, main_d;
    data_t skid_q, skid_d;
    logic  main_v, main_v_d;
    logic  skid_v, skid_v_d;
    logic  ready_q;
    logic  in_fire;
    logic  main_free;

    assign in_fire   = in_valid && ready_q;
    assign main_free = !main_v || out_ready;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned
        // (which would infer a latch).
        main_v_d = main_v;
        main_d   = main_q;
        skid_v_d = skid_v;
        skid_d   = skid_q;
        if (main_free) begin
            if (skid_v) begin
                main_v_d = 1'b1;
                main_d   = skid_q;
                skid_v_d = in_fire;
                if (in_fire) skid_d = in_data;
            end else begin
                main_v_d = in_fire;
                if (in_fire) main_d = in_data;
            end
        end else if (in_fire) begin
            skid_v_d = 1'b1;
            skid_d   = in_data;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use <= so every flop samples pre-edge values;
        // blocking = here would create order-dependent simulation results.
        if (RESET) begin
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b0;
            // NOTE: payload registers are cleared too so nothing stale survives a
            // mid-operation reset; the valid bits alone would suffice for control.
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            main_v  <= main_v_d;
            skid_v  <= skid_v_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= !skid_v_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_v;
    assign out_data  = main_q;

endmodule

// File: rtl/shl_skid_stage.sv
// Registered ready/valid left-shift stage: skid buffer -> coreir_shl -> output
// register. Define SHL_SKID_OVF_EN to add the registered OVF output.
module shl_skid_stage
    import shl_skid_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] I0,
    input  logic [width-1:0] I1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] O
`ifdef SHL_SKID_OVF_EN
    ,
    output logic             OVF
`endif
);

    typedef struct packed {
        logic [width-1:0] a;
        logic [width-1:0] amt;
    } op_t;

    op_t              in_op;
    op_t              main_op;
    logic             main_valid;
    logic             main_ready;
    logic [width-1:0] shl_out;

    assign in_op      = '{a: I0, amt: I1};
    // Main advances when the output register is empty or being drained.
    assign main_ready = !out_valid || out_ready;

    shl_skid_buffer #(
        .data_t (op_t)
    ) u_buf (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_op),
        .out_valid (main_valid),
        .out_ready (main_ready),
        .out_data  (main_op)
    );

    coreir_shl #(
        .width (width)
    ) u_shl (
        .in0 (main_op.a),
        .in1 (main_op.amt),
        .out (shl_out)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid <= 1'b0;
            O         <= '0;
        end else if (main_ready) begin
            out_valid <= main_valid;
            if (main_valid) O <= shl_out;
        end
    end

`ifdef SHL_SKID_OVF_EN
    // Bits lost are the top 'amt' bits of a; ones >> amt clears exactly those,
    // and an amount >= width clears all of them.
    logic [width-1:0] keep_mask;
    logic             ovf_d;

    assign keep_mask = {width{1'b1}} >> main_op.amt;
    assign ovf_d     = |(main_op.a & ~keep_mask);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            OVF <= 1'b0;
        end else if (main_ready && main_valid) begin
            OVF <= ovf_d;
        end
    end
`endif

endmodule
